// File: rtl/ycr_req_arb.sv
// Round-robin arbiter sharing one downstream request path among N_REQ requesters.
// An in-order tag FIFO remembers each winner so responses are routed back to it.
module ycr_req_arb #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned CMD_W  = 50,
  parameter int unsigned RESP_W = 33,
  parameter int unsigned OUT_DP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           up_req,
  input  logic [N_REQ*CMD_W-1:0]     up_cmd,
  output logic [N_REQ-1:0]           up_req_ack,
  output logic [N_REQ-1:0]           up_resp_valid,
  output logic [RESP_W-1:0]          up_resp_data,
  output logic                       dn_req,
  output logic [CMD_W-1:0]           dn_cmd,
  input  logic                       dn_req_ack,
  input  logic                       dn_resp_valid,
  input  logic [RESP_W-1:0]          dn_resp_data,
  output logic [$clog2(OUT_DP):0]    outstanding,
  output logic                       resp_err
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PW  = $clog2(OUT_DP);
  localparam int unsigned CW  = PW + 1;
  localparam logic [IDW:0]   NREQ_L  = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
  localparam logic [CW-1:0]  FULL_L  = CW'(OUT_DP);

  typedef enum logic {S_FREE, S_LOCK} lock_state_t;

  lock_state_t          r_state;
  lock_state_t          w_state_nxt;
  logic [IDW-1:0]       r_lock_id;
  logic [IDW-1:0]       r_rr_ptr;

  logic [IDW-1:0]       r_mem [OUT_DP];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_cnt;
  logic                 r_resp_err;

  logic [CMD_W-1:0]     w_cmd [N_REQ];
  logic                 w_rr_hit;
  logic [IDW-1:0]       w_rr_id;
  logic [IDW-1:0]       w_grant_id;
  logic                 w_grant_vld;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_xfer;
  logic                 w_pop;
  logic [IDW-1:0]       w_head;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_cmd[i] = up_cmd[i*CMD_W +: CMD_W];
    end
  end

  // First requesting index at or after rr_ptr, wrapping at N_REQ.
  always_comb begin : rr_scan
    logic [IDW:0] v_idx;
    v_idx    = '0;
    w_rr_hit = 1'b0;
    w_rr_id  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (v_idx >= NREQ_L) v_idx = v_idx - NREQ_L;
      if (!w_rr_hit && up_req[v_idx[IDW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_id  = v_idx[IDW-1:0];
      end
    end
  end

  assign w_full  = (r_cnt == FULL_L);
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FREE;
      r_lock_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FREE && dn_req && !dn_req_ack) r_lock_id <= w_rr_id;
    end
  end

  // Lock FSM: next state; a dropped request while locked abandons the lock.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE: if (dn_req && !dn_req_ack) w_state_nxt = S_LOCK;
      S_LOCK: if (w_xfer || !up_req[r_lock_id]) w_state_nxt = S_FREE;
      default: w_state_nxt = S_FREE;
    endcase
  end

  // Lock FSM: outputs (grant, downstream request, acceptance)
  always_comb begin
    w_grant_id  = w_rr_id;
    w_grant_vld = w_rr_hit;
    if (r_state == S_LOCK) begin
      w_grant_id  = r_lock_id;
      w_grant_vld = up_req[r_lock_id];
    end
    dn_req = w_grant_vld && !w_full && !rst;
    dn_cmd = dn_req ? w_cmd[w_grant_id] : '0;
    w_xfer = dn_req && dn_req_ack;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      up_req_ack[i] = w_xfer && (w_grant_id == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + 1'b1;
    end
  end

  // Responses with nothing outstanding are dropped and flagged, never popped.
  assign w_pop = dn_resp_valid && !w_empty && !rst;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      up_resp_valid[i] = w_pop && (w_head == IDW'(i));
    end
  end

  assign up_resp_data = dn_resp_data;

  always_ff @(posedge clk) begin
    if (w_xfer) r_mem[r_wr_ptr] <= w_grant_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_xfer) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_xfer, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (dn_resp_valid && w_empty) r_resp_err <= 1'b1;
    end
  end

  assign outstanding = r_cnt;
  assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_ycr_req_arb.sv
// Directed bench for ycr_req_arb: grant order, lock, outstanding limit,
// response routing through an expected-ID scoreboard, error flag and reset.
module tb_ycr_req_arb;
  localparam int unsigned N_REQ  = 2;
  localparam int unsigned CMD_W  = 50;
  localparam int unsigned RESP_W = 33;
  localparam int unsigned OUT_DP = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       up_req;
  logic [N_REQ*CMD_W-1:0] up_cmd;
  logic [N_REQ-1:0]       up_req_ack;
  logic [N_REQ-1:0]       up_resp_valid;
  logic [RESP_W-1:0]      up_resp_data;
  logic                   dn_req;
  logic [CMD_W-1:0]       dn_cmd;
  logic                   dn_req_ack;
  logic                   dn_resp_valid;
  logic [RESP_W-1:0]      dn_resp_data;
  logic [$clog2(OUT_DP):0] outstanding;
  logic                   resp_err;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ycr_req_arb #(
    .N_REQ (N_REQ),
    .CMD_W (CMD_W),
    .RESP_W(RESP_W),
    .OUT_DP(OUT_DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .up_req       (up_req),
    .up_cmd       (up_cmd),
    .up_req_ack   (up_req_ack),
    .up_resp_valid(up_resp_valid),
    .up_resp_data (up_resp_data),
    .dn_req       (dn_req),
    .dn_cmd       (dn_cmd),
    .dn_req_ack   (dn_req_ack),
    .dn_resp_valid(dn_resp_valid),
    .dn_resp_data (dn_resp_data),
    .outstanding  (outstanding),
    .resp_err     (resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [CMD_W-1:0] c);
    up_cmd[i*CMD_W +: CMD_W] = c;
  endtask

  // Expect a transfer to requester id this cycle and record it on the scoreboard.
  task automatic grant(input string tag, input int id, input logic [CMD_W-1:0] c);
    chk({tag, "_dn_req"}, 64'(dn_req), 64'd1);
    chk({tag, "_dn_cmd"}, 64'(dn_cmd), 64'(c));
    chk({tag, "_ack"}, 64'(up_req_ack), 64'd1 << id);
    exp_q.push_back(id);
  endtask

  // Check routing of the response currently on dn_resp_* against the scoreboard head.
  task automatic chk_route(input string tag, input logic [RESP_W-1:0] d);
    int id;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed=response expected=no_response_outstanding", tag);
    end else begin
      id = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(up_resp_valid), 64'd1 << id);
      chk({tag, "_data"}, 64'(up_resp_data), 64'(d));
    end
  endtask

  task automatic resp(input string tag, input logic [RESP_W-1:0] d);
    dn_resp_valid = 1'b1;
    dn_resp_data  = d;
    settle();
    chk_route(tag, d);
    cyc();
    dn_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst           = 1'b1;
    up_req        = 2'b11;
    up_cmd        = '0;
    dn_req_ack    = 1'b1;
    dn_resp_valid = 1'b1;
    dn_resp_data  = '0;

    // Reset: outputs forced low even with activity on the inputs
    cyc();
    chk("rst_dn_req", 64'(dn_req), 64'd0);
    chk("rst_ack", 64'(up_req_ack), 64'd0);
    chk("rst_resp_valid", 64'(up_resp_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    cyc();
    rst = 1'b0; up_req = '0; dn_resp_valid = 1'b0;
    settle();
    chk("idle_dn_req", 64'(dn_req), 64'd0);

    // Single requester, zero-latency forwarding
    set_cmd(1, 50'h155); up_req = 2'b10;
    settle();
    grant("single", 1, 50'h155);
    cyc();
    up_req = '0;
    settle();
    chk("single_ack_pulse", 64'(up_req_ack), 64'd0);
    chk("single_outstanding", 64'(outstanding), 64'd1);
    resp("single_resp", 33'h1_2345_6789);
    settle();
    chk("single_drained", 64'(outstanding), 64'd0);

    // Round-robin alternation with push and pop in the same cycle
    set_cmd(0, 50'hA0); set_cmd(1, 50'hB1); up_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        dn_resp_valid = 1'b1;
        dn_resp_data  = RESP_W'(k);
      end
      settle();
      if (k > 0) begin
        chk_route("rr_resp", RESP_W'(k));
        chk("rr_occupancy", 64'(outstanding), 64'd1);
      end
      grant("rr", k % 2, (k % 2) ? 50'hB1 : 50'hA0);
      cyc();
    end
    up_req = '0; dn_resp_valid = 1'b0;
    settle();
    chk("rr_push_pop_occ", 64'(outstanding), 64'd1);
    resp("rr_last", 33'h4);

    // Backpressure lock: command held on the locked requester
    set_cmd(0, 50'h111); set_cmd(1, 50'h222); up_req = 2'b01; dn_req_ack = 1'b0;
    settle();
    chk("lock0_dn_req", 64'(dn_req), 64'd1);
    chk("lock0_cmd", 64'(dn_cmd), 64'h111);
    chk("lock0_ack", 64'(up_req_ack), 64'd0);
    cyc();
    up_req = 2'b11;
    settle();
    chk("lock1_cmd", 64'(dn_cmd), 64'h111);
    chk("lock1_ack", 64'(up_req_ack), 64'd0);
    cyc();
    settle();
    chk("lock2_cmd", 64'(dn_cmd), 64'h111);
    cyc();
    dn_req_ack = 1'b1;
    settle();
    grant("lock_accept", 0, 50'h111);
    cyc();
    settle();
    grant("lock_next", 1, 50'h222);
    cyc();
    up_req = '0;
    settle();
    chk("lock_outstanding", 64'(outstanding), 64'd2);
    resp("lock_r0", 33'h21);
    resp("lock_r1", 33'h22);

    // Outstanding limit and pre-pop full check
    set_cmd(0, 50'h3C3); up_req = 2'b01;
    for (int k = 0; k < 4; k++) begin
      settle();
      grant("lim", 0, 50'h3C3);
      cyc();
    end
    settle();
    chk("lim_full_dn_req", 64'(dn_req), 64'd0);
    chk("lim_full_ack", 64'(up_req_ack), 64'd0);
    chk("lim_full_occ", 64'(outstanding), 64'd4);
    dn_resp_valid = 1'b1; dn_resp_data = 33'h55;
    settle();
    chk("lim_prepop_dn_req", 64'(dn_req), 64'd0);
    chk_route("lim_pop", 33'h55);
    cyc();
    dn_resp_valid = 1'b0;
    settle();
    chk("lim_freed_occ", 64'(outstanding), 64'd3);
    grant("lim_reassert", 0, 50'h3C3);
    cyc();
    up_req = '0;
    settle();
    chk("lim_refull_occ", 64'(outstanding), 64'd4);
    for (int k = 0; k < 4; k++) resp("lim_drain", RESP_W'(33'h60 + k));

    // Response routing in issue order 1,0,1
    set_cmd(0, 50'h2A0); set_cmd(1, 50'h2A1);
    up_req = 2'b10; settle(); grant("route_i0", 1, 50'h2A1); cyc();
    up_req = 2'b01; settle(); grant("route_i1", 0, 50'h2A0); cyc();
    up_req = 2'b10; settle(); grant("route_i2", 1, 50'h2A1); cyc();
    up_req = '0;
    resp("route_A", 33'hA);
    resp("route_B", 33'hB);
    resp("route_C", 33'hC);

    // Response with nothing outstanding, then reset with tags in flight
    dn_resp_valid = 1'b1; dn_resp_data = 33'h77;
    settle();
    chk("err_dropped", 64'(up_resp_valid), 64'd0);
    cyc();
    dn_resp_valid = 1'b0;
    settle();
    chk("err_set", 64'(resp_err), 64'd1);
    cyc(); cyc();
    chk("err_sticky", 64'(resp_err), 64'd1);
    set_cmd(0, 50'h9); up_req = 2'b01;
    settle(); grant("pre_rst0", 0, 50'h9); cyc();
    settle(); grant("pre_rst1", 0, 50'h9); cyc();
    up_req = '0;
    settle();
    chk("pre_rst_occ", 64'(outstanding), 64'd2);
    rst = 1'b1; up_req = 2'b11;
    settle();
    chk("in_rst_dn_req", 64'(dn_req), 64'd0);
    chk("in_rst_ack", 64'(up_req_ack), 64'd0);
    cyc();
    rst = 1'b0; up_req = '0;
    exp_q.delete();
    settle();
    chk("post_rst_occ", 64'(outstanding), 64'd0);
    chk("post_rst_err", 64'(resp_err), 64'd0);
    chk("post_rst_dn_req", 64'(dn_req), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
